cheby_inverse_solver: RTL and testbench

CHEBY_INVERSE_SOLVER -- requirements
Module: cheby_inverse_solver

---
 rtl/cheby_inverse_solver.sv | 194 +++++++++++++++++++
 tb/tb_cheby_inverse_solver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cheby_inverse_solver.sv
`default_nettype none
// ============================================================================
// Module   : cheby_inverse_solver
// Brief    : Inverts a monotone forward evaluator over [-6.0, 6.0) by binary
//            search, driving the probe abscissa and sampling its latent result.
// Revision : 1.0 - initial release
// ============================================================================
module cheby_inverse_solver #(
    parameter int LAT  = 4,
    parameter int FRAC = 12
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               start,
    input  logic signed [17:0] target,
    output logic signed [17:0] x_probe,
    input  logic signed [17:0] y_probe,
    output logic               busy,
    output logic               done,
    output logic signed [17:0] x_out,
    output logic               sat_lo,
    output logic               sat_hi
);

    localparam int                 C_WW         = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [C_WW-1:0]    C_WAIT_LAST  = C_WW'(LAT);
    localparam logic signed [17:0] C_XMIN       = 18'(-6 * (1 << FRAC));
    localparam logic signed [17:0] C_XMAX       = 18'(6 * (1 << FRAC) - 1);
    localparam logic [4:0]         C_MAX_PROBES = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PROBE_HI = 3'd1,
        ST_PROBE_LO = 3'd2,
        ST_SEARCH   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t             r_state, w_state;
    logic signed [17:0] r_target, w_target;
    logic signed [17:0] r_lo, w_lo;
    logic signed [17:0] r_hi, w_hi;
    logic signed [17:0] r_x_probe, w_x_probe;
    logic signed [17:0] r_x_out, w_x_out;
    logic [C_WW-1:0]    r_wcnt, w_wcnt;
    logic [4:0]         r_iter, w_iter;
    logic               r_sat_lo, w_sat_lo;
    logic               r_sat_hi, w_sat_hi;

    logic               w_wait_end;
    logic signed [17:0] w_upd_lo;
    logic signed [17:0] w_upd_hi;
    logic [4:0]         w_iter_inc;

    // Floor of the midpoint: 19-bit sum so lo+hi never wraps, then arithmetic shift.
    function automatic logic signed [17:0] f_mid(input logic signed [17:0] a,
                                                 input logic signed [17:0] b);
        logic signed [18:0] s;
        s = 19'(a) + 19'(b);
        return 18'(s >>> 1);
    endfunction

    assign w_wait_end = (r_wcnt == C_WAIT_LAST);
    assign w_iter_inc = r_iter + 5'd1;

    // While in SEARCH the held probe value is the current midpoint.
    assign w_upd_lo = (y_probe < r_target) ? (r_x_probe + 18'sd1) : r_lo;
    assign w_upd_hi = (y_probe < r_target) ? r_hi : r_x_probe;

    always_comb begin
        w_state   = r_state;
        w_target  = r_target;
        w_lo      = r_lo;
        w_hi      = r_hi;
        w_x_probe = r_x_probe;
        w_x_out   = r_x_out;
        w_wcnt    = r_wcnt;
        w_iter    = r_iter;
        w_sat_lo  = r_sat_lo;
        w_sat_hi  = r_sat_hi;
        busy      = 1'b0;
        done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_target  = target;
                    w_lo      = C_XMIN;
                    w_hi      = C_XMAX;
                    w_x_probe = C_XMAX;
                    w_wcnt    = '0;
                    w_iter    = '0;
                    w_sat_lo  = 1'b0;
                    w_sat_hi  = 1'b0;
                    w_state   = ST_PROBE_HI;
                end
            end

            ST_PROBE_HI: begin
                busy = 1'b1;
                if (!w_wait_end) begin
                    w_wcnt = r_wcnt + 1'b1;
                end else if (y_probe < r_target) begin
                    w_x_out  = C_XMAX;
                    w_sat_hi = 1'b1;
                    w_state  = ST_DONE;
                end else begin
                    w_x_probe = C_XMIN;
                    w_wcnt    = '0;
                    w_state   = ST_PROBE_LO;
                end
            end

            ST_PROBE_LO: begin
                busy = 1'b1;
                if (!w_wait_end) begin
                    w_wcnt = r_wcnt + 1'b1;
                end else if (y_probe > r_target) begin
                    w_x_out  = C_XMIN;
                    w_sat_lo = 1'b1;
                    w_state  = ST_DONE;
                end else if (r_lo == r_hi) begin
                    w_x_out = r_lo;
                    w_state = ST_DONE;
                end else begin
                    w_x_probe = f_mid(r_lo, r_hi);
                    w_wcnt    = '0;
                    w_iter    = '0;
                    w_state   = ST_SEARCH;
                end
            end

            ST_SEARCH: begin
                busy = 1'b1;
                if (!w_wait_end) begin
                    w_wcnt = r_wcnt + 1'b1;
                end else begin
                    w_lo   = w_upd_lo;
                    w_hi   = w_upd_hi;
                    w_iter = w_iter_inc;
                    if ((w_upd_lo == w_upd_hi) || (w_iter_inc >= C_MAX_PROBES)) begin
                        w_x_out = w_upd_lo;
                        w_state = ST_DONE;
                    end else begin
                        w_x_probe = f_mid(w_upd_lo, w_upd_hi);
                        w_wcnt    = '0;
                    end
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_target  <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_x_probe <= '0;
            r_x_out   <= '0;
            r_wcnt    <= '0;
            r_iter    <= '0;
            r_sat_lo  <= 1'b0;
            r_sat_hi  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_target  <= w_target;
            r_lo      <= w_lo;
            r_hi      <= w_hi;
            r_x_probe <= w_x_probe;
            r_x_out   <= w_x_out;
            r_wcnt    <= w_wcnt;
            r_iter    <= w_iter;
            r_sat_lo  <= w_sat_lo;
            r_sat_hi  <= w_sat_hi;
        end
    end

    assign x_probe = r_x_probe;
    assign x_out   = r_x_out;
    assign sat_lo  = r_sat_lo;
    assign sat_hi  = r_sat_hi;

endmodule
`default_nettype wire

// File: tb/tb_cheby_inverse_solver.sv
`default_nettype none
// ============================================================================
// Module   : tb_cheby_inverse_solver
// Brief    : Directed bench for cheby_inverse_solver with identity/step models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cheby_inverse_solver;

    localparam int LAT = 4;

    logic               clock = 1'b0;
    logic               rst   = 1'b0;
    logic               start = 1'b0;
    logic signed [17:0] target = '0;
    logic signed [17:0] x_probe;
    logic signed [17:0] y_probe;
    logic               busy;
    logic               done;
    logic signed [17:0] x_out;
    logic               sat_lo;
    logic               sat_hi;

    int total = 0;
    int bad   = 0;
    int model_sel = 0;
    logic signed [17:0] dl [0:LAT-1];

    cheby_inverse_solver #(.LAT(LAT), .FRAC(12)) dut (
        .clock   (clock),
        .rst     (rst),
        .start   (start),
        .target  (target),
        .x_probe (x_probe),
        .y_probe (y_probe),
        .busy    (busy),
        .done    (done),
        .x_out   (x_out),
        .sat_lo  (sat_lo),
        .sat_hi  (sat_hi)
    );

    always #5 clock = ~clock;

    function automatic logic signed [17:0] fmodel(input logic signed [17:0] x, input int sel);
        if (sel == 0) return x;
        return (x < 18'sh01000) ? 18'sh00000 : 18'sh01000;
    endfunction

    // Forward evaluator: f(x_probe) appears on y_probe LAT cycles after x_probe changes.
    always @(posedge clock) begin
        dl[0] <= fmodel(x_probe, model_sel);
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
    assign y_probe = dl[LAT-1];

    task automatic chk(input string tag, input logic [17:0] act, input logic [17:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic launch(input logic [17:0] tgt);
        @(negedge clock);
        target = tgt;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [17:0] tgt, input logic [17:0] exp_x,
                       input logic exp_lo, input logic exp_hi, input int exp_cyc);
        int cyc;
        launch(tgt);
        chk({tag, ".busy_start"}, 18'(busy), 18'd1);
        wait_done(cyc);
        chk({tag, ".done_seen"}, 18'(done), 18'd1);
        chk({tag, ".busy_at_done"}, 18'(busy), 18'd0);
        chk({tag, ".x_out"}, x_out, exp_x);
        chk({tag, ".sat_lo"}, 18'(sat_lo), 18'(exp_lo));
        chk({tag, ".sat_hi"}, 18'(sat_hi), 18'(exp_hi));
        if (exp_cyc > 0) chk({tag, ".cycles"}, 18'(cyc), 18'(exp_cyc));
        else             chk({tag, ".within92"}, 18'(cyc <= 92), 18'd1);
        @(negedge clock);
        chk({tag, ".done_single"}, 18'(done), 18'd0);
        chk({tag, ".x_out_held"}, x_out, exp_x);
    endtask

    initial begin
        int cyc;
        int saw_done;
        for (int i = 0; i < LAT; i++) dl[i] = '0;

        repeat (2) @(negedge clock);
        chk("rst.busy", 18'(busy), 18'd0);
        chk("rst.done", 18'(done), 18'd0);
        chk("rst.x_out", x_out, 18'h00000);
        chk("rst.x_probe", x_probe, 18'h00000);
        chk("rst.sat", 18'({sat_lo, sat_hi}), 18'd0);
        rst = 1'b1;

        model_sel = 0;
        run("id_half",   18'h00800, 18'h00800, 1'b0, 1'b0, 0);
        run("id_sathi",  18'h07000, 18'h05FFF, 1'b0, 1'b1, 6);
        run("id_satlo",  18'h38000, 18'h3A000, 1'b1, 1'b0, 11);
        run("id_xmin",   18'h3A000, 18'h3A000, 1'b0, 1'b0, 0);
        run("id_xmax",   18'h05FFF, 18'h05FFF, 1'b0, 1'b0, 0);
        run("id_neg1",   18'h3F000, 18'h3F000, 1'b0, 1'b0, 0);
        run("id_zero",   18'h00000, 18'h00000, 1'b0, 1'b0, 0);

        model_sel = 1;
        run("step_1",    18'h00001, 18'h01000, 1'b0, 1'b0, 0);
        run("step_one",  18'h01000, 18'h01000, 1'b0, 1'b0, 0);
        run("step_0",    18'h00000, 18'h3A000, 1'b0, 1'b0, 0);

        // A start during busy must not recapture the target.
        model_sel = 0;
        launch(18'h00800);
        repeat (3) @(negedge clock);
        target = 18'h00100;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        chk("ign.busy", 18'(busy), 18'd1);
        wait_done(cyc);
        chk("ign.done_seen", 18'(done), 18'd1);
        chk("ign.x_out", x_out, 18'h00800);
        @(negedge clock);

        // Reset in the middle of SEARCH aborts without a done pulse.
        launch(18'h00400);
        repeat (15) @(negedge clock);
        chk("abort.busy_before", 18'(busy), 18'd1);
        rst = 1'b0;
        #1;
        chk("abort.busy", 18'(busy), 18'd0);
        chk("abort.done", 18'(done), 18'd0);
        chk("abort.x_out", x_out, 18'h00000);
        chk("abort.x_probe", x_probe, 18'h00000);
        saw_done = 0;
        repeat (3) begin
            @(negedge clock);
            if (done) saw_done = 1;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clock);
            if (done) saw_done = 1;
        end
        chk("abort.no_done", 18'(saw_done), 18'd0);
        run("after_rst", 18'h3F800, 18'h3F800, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
